bcd_serial_collector: RTL and testbench
=======================================

# bcd_serial_collector

Downstream stage of the serial Excess-3→BCD converter. It samples the converter's serial output Z one bit per strobe, LSB first, and reassembles each group of 4 bits into a parallel BCD digit. Completed digits go into a small digit FIFO, which a consumer (display or accumulator logic) drains through a valid/ready handshake. Framing errors and FIFO overflow are flagged for the bench and downstream logic.

## Interface
Parameters:
- DEPTH, 4: digit FIFO depth in entries; power of two, minimum 2.
- PTR_W, $clog2(DEPTH): FIFO pointer width; derived, do not override.

Ports:
- Clk  input  1  clock; all state updates on posedge.
- Rst  input  1  synchronous, active-high reset.
- Bit_en  input  1  strobe: Z is valid this cycle.
- Bit_first  input  1  qualifies Bit_en: this bit is bit 0 (LSB) of a new digit.
- Z  input  1  serial BCD bit from the converter.
- Digit_out  output  4  BCD digit at FIFO head.
- Digit_valid  output  1  FIFO non-empty.
- Digit_ready  input  1  consumer accepts the head digit when Digit_valid is also high.
- Frame_err  output  1  one-cycle pulse when a partial digit is discarded.
- Overflow  output  1  sticky; set when a completed digit is dropped because the FIFO is full.
- Fill  output  PTR_W+1  current FIFO occupancy.

## Operation
- Collector FSM (state register plus 4-bit shift register):
  - IDLE → B1 on Bit_en&&Bit_first; the bit is stored at position 0.
  - B1 → B2 → B3 on each Bit_en; the bit is stored at position 1, 2, 3 respectively. Bits fill LSB first.
  - B3 completes the digit on its Bit_en, issues one push, then returns to IDLE.
  - If Bit_first arrives in B1/B2/B3: discard the partial digit, pulse Frame_err, and restart in B1 with the new bit as bit 0.
  - Bit_en without Bit_first in IDLE: ignore the bit and pulse Frame_err.
  - Cycles without Bit_en hold the state; gaps between bits are legal.
- FIFO write: on a completed digit.
  - Accepted if Fill<DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the digit is dropped and Overflow is set.
- FIFO read: on Digit_valid && Digit_ready, the head advances.
  - Digit_out shows the new head on the next cycle.
  - Simultaneous push and pop on empty: the pop is ignored (Digit_valid is low) and the push lands.
- Pointers wrap modulo DEPTH. Fill is tracked separately to distinguish full from empty.
- Digit_out is a don't-care when Digit_valid is low but is driven to 0 after reset.

## Timing
- Reset values:
  - FSM=IDLE, shift register=0, Fill=0.
  - Digit_valid=0, Digit_out=0, Frame_err=0, Overflow=0.
- Rst has priority over all inputs in the same cycle. Reset mid-digit or mid-drain discards all contents.
- Latency: the 4th bit is sampled at edge N; Digit_valid is high and Digit_out is valid after edge N (registered, 1 cycle).
- Throughput: one digit per 4 strobes. The FIFO sustains push and pop in the same cycle.
- Frame_err is high for exactly the cycle after the offending edge.
- Overflow stays high until Rst.

## Configuration
- Macro BCD_RANGE_CHECK_EN.
- Defined:
  - A completed digit >9 (1010–1111) is not pushed; it pulses Frame_err instead.
  - Valid digits behave as normal.
- Undefined:
  - All 16 codes are pushed unchanged and no range logic is compiled.
  - Frame_err comes only from framing violations.

## Structure
- Shared package bcd_collector_pkg:
  - Collector state enum (IDLE, B1, B2, B3).
  - DIGIT_W=4.
  - BCD_MAX=4'd9.
- Sub-module bcd_digit_fifo, parameterised on DEPTH: storage, pointers, Fill, and push/pop arbitration.
- The top level holds the FSM, shift register, range check and Overflow.

## Test plan
- Reset, then serial bits 1,0,0,1 (LSB first) with Bit_first on the first → Digit_out=4'b1001 and Digit_valid=1 the cycle after the 4th bit; Fill=1.
- Stream digits 0..9 back to back with Digit_ready=1 → ten digits out in order 0..9; Overflow=0; Frame_err never high.
- Digit_ready=0, push DEPTH+1 digits (3,1,4,1,5) with DEPTH=4 → Fill=4; Overflow=1; draining yields 3,1,4,1; the digit 5 is lost.
- Bits 1,1 then Bit_first with 0,1,1,0 → Frame_err pulses once; only digit 6 is pushed.
- Code 1100 with BCD_RANGE_CHECK_EN → no push and a Frame_err pulse. Without the macro → Digit_out=4'hC.
- Rst asserted after 2 bits and with Fill=2 → next cycle Fill=0, Digit_valid=0, FSM=IDLE; the following well-framed digit 7 is collected correctly.

Source files
------------

// File: rtl/bcd_collector_pkg.sv
// Shared types and constants for the serial BCD digit collector.
// Holds the collector state encoding and digit-width constants.
// Imported by the top level and the digit FIFO.
package bcd_collector_pkg;

   localparam int DIGIT_W = 4;
   localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      B1   = 2'd1,
      B2   = 2'd2,
      B3   = 2'd3
   } coll_state_e;

endpackage

// File: rtl/bcd_digit_fifo.sv
// Small digit FIFO: DEPTH entries, pointers wrap modulo DEPTH, occupancy tracked in fill.
// Latency: a pushed digit is visible at the head the cycle after the push edge.
// Backpressure: push_rdy drops when full unless a pop happens in the same cycle.
module bcd_digit_fifo
   import bcd_collector_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               push_vld,
   input  logic [DIGIT_W-1:0] push_dat,
   output logic               push_rdy,
   output logic               pop_vld,
   input  logic               pop_rdy,
   output logic [DIGIT_W-1:0] pop_dat,
   output logic [PTR_W:0]     fill
);

   localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(DEPTH);

   logic [DIGIT_W-1:0] mem_q [DEPTH];
   logic [DIGIT_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]     fill_q, fill_d;
   logic               pop_fire;
   logic               push_fire;

   // Pop only when non-empty; a pop in the same cycle frees a slot for a push into a full FIFO.
   always_comb begin
      pop_fire  = (fill_q != '0) && pop_rdy;
      push_rdy  = (fill_q < FULL_LVL) || pop_fire;
      push_fire = push_vld && push_rdy;

      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      fill_d   = fill_q;

      if (push_fire) begin
         mem_d[wr_ptr_q] = push_dat;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_fire) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_fire, pop_fire})
         2'b10:   fill_d = fill_q + (PTR_W+1)'(1);
         2'b01:   fill_d = fill_q - (PTR_W+1)'(1);
         default: fill_d = fill_q;
      endcase
   end

   // Storage is cleared on reset so the head reads as zero afterwards.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         fill_q   <= fill_d;
      end
   end

   assign pop_vld = (fill_q != '0);
   assign pop_dat = mem_q[rd_ptr_q];
   assign fill    = fill_q;

endmodule

// File: rtl/bcd_serial_collector.sv
// Reassembles LSB-first serial BCD bits into 4-bit digits and queues them in a digit FIFO.
// Latency: digit visible at Digit_out one cycle after its 4th bit is sampled.
// Backpressure: none on the serial side; a digit completed into a full FIFO is dropped and Overflow sticks.
// Optional build macro BCD_RANGE_CHECK_EN rejects completed codes above 9 with a Frame_err pulse.
module bcd_serial_collector
   import bcd_collector_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic               Bit_en,
   input  logic               Bit_first,
   input  logic               Z,
   output logic [DIGIT_W-1:0] Digit_out,
   output logic               Digit_valid,
   input  logic               Digit_ready,
   output logic               Frame_err,
   output logic               Overflow,
   output logic [PTR_W:0]     Fill
);

   coll_state_e        state_q, state_d;
   logic [DIGIT_W-1:0] shift_q, shift_d;
   logic               frame_err_q, frame_err_d;
   logic               overflow_q, overflow_d;
   logic               push_vld;
   logic               push_rdy;
   logic [DIGIT_W-1:0] digit_full;
   logic               complete;

   // Bit 3 of the shift register is always zero while collecting (cleared on every Bit_first),
   // so OR-ing in Z gives the finished digit in the same cycle the last bit arrives.
   assign digit_full = {shift_q[3] | Z, shift_q[2:0]};

   // Next-state, shift, push request and error flags for the collector.
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      frame_err_d = 1'b0;
      overflow_d  = overflow_q;
      push_vld    = 1'b0;
      complete    = 1'b0;

      if (Bit_en) begin
         if (Bit_first) begin
            if (state_q != IDLE) frame_err_d = 1'b1;
            state_d = B1;
            shift_d = {3'b000, Z};
         end else begin
            case (state_q)
               IDLE: frame_err_d = 1'b1;
               B1: begin
                  shift_d[1] = Z;
                  state_d    = B2;
               end
               B2: begin
                  shift_d[2] = Z;
                  state_d    = B3;
               end
               B3: begin
                  shift_d[3] = Z;
                  state_d    = IDLE;
                  complete   = 1'b1;
               end
               default: state_d = IDLE;
            endcase
         end
      end

`ifdef BCD_RANGE_CHECK_EN
      if (complete) begin
         if (digit_full > BCD_MAX) frame_err_d = 1'b1;
         else                      push_vld    = 1'b1;
      end
`else
      push_vld = complete;
`endif

      if (push_vld && !push_rdy) overflow_d = 1'b1;
   end

   // Collector FSM and registered status outputs; reset wins over everything.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         frame_err_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         frame_err_q <= frame_err_d;
         overflow_q  <= overflow_d;
      end
   end

   bcd_digit_fifo #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_fifo (
      .clk      (Clk),
      .rst      (Rst),
      .push_vld (push_vld),
      .push_dat (digit_full),
      .push_rdy (push_rdy),
      .pop_vld  (Digit_valid),
      .pop_rdy  (Digit_ready),
      .pop_dat  (Digit_out),
      .fill     (Fill)
   );

   assign Frame_err = frame_err_q;
   assign Overflow  = overflow_q;

endmodule

// File: tb/tb_bcd_serial_collector.sv
// Directed bench for bcd_serial_collector (DEPTH=4).
// Inputs driven on negedge, outputs sampled on negedge; pops recorded at posedge.
module tb_bcd_serial_collector;
   import bcd_collector_pkg::*;

   logic       Clk = 1'b0;
   logic       Rst = 1'b0;
   logic       Bit_en = 1'b0;
   logic       Bit_first = 1'b0;
   logic       Z = 1'b0;
   logic [3:0] Digit_out;
   logic       Digit_valid;
   logic       Digit_ready = 1'b0;
   logic       Frame_err;
   logic       Overflow;
   logic [2:0] Fill;

   int checks = 0;
   int errors = 0;
   logic [3:0] popq[$];
   int fe_count = 0;

   bcd_serial_collector #(.DEPTH(4)) dut (
      .Clk(Clk), .Rst(Rst), .Bit_en(Bit_en), .Bit_first(Bit_first), .Z(Z),
      .Digit_out(Digit_out), .Digit_valid(Digit_valid), .Digit_ready(Digit_ready),
      .Frame_err(Frame_err), .Overflow(Overflow), .Fill(Fill)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) begin
      if (!Rst && Digit_valid && Digit_ready) popq.push_back(Digit_out);
      if (Frame_err) fe_count++;
   end

   task automatic do_reset();
      @(negedge Clk);
      Rst = 1'b1; Bit_en = 1'b0; Bit_first = 1'b0; Z = 1'b0; Digit_ready = 1'b0;
      @(negedge Clk);
      Rst = 1'b0;
      popq.delete();
      fe_count = 0;
   endtask

   task automatic send_bit(input logic z, input logic first);
      @(negedge Clk);
      Bit_en = 1'b1; Bit_first = first; Z = z;
      @(negedge Clk);
      Bit_en = 1'b0; Bit_first = 1'b0;
   endtask

   task automatic send_digit(input logic [3:0] d);
      for (int b = 0; b < 4; b++) send_bit(d[b], b == 0);
   endtask

   task automatic drain(input int cycles);
      @(negedge Clk);
      Digit_ready = 1'b1;
      repeat (cycles) @(negedge Clk);
      Digit_ready = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (Digit_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", Digit_valid); end
      checks++; if (Digit_out !== 4'd0) begin errors++; $display("FAIL reset_dout got %h want 0", Digit_out); end
      checks++; if (Fill !== 3'd0) begin errors++; $display("FAIL reset_fill got %0d want 0", Fill); end
      checks++; if (Frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", Frame_err); end
      checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", Overflow); end
   endtask

   task automatic test_single_digit();
      do_reset();
      send_bit(1'b1, 1'b1);
      send_bit(1'b0, 1'b0);
      send_bit(1'b0, 1'b0);
      checks++; if (Digit_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b want 0", Digit_valid); end
      send_bit(1'b1, 1'b0);
      checks++; if (Digit_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", Digit_valid); end
      checks++; if (Digit_out !== 4'b1001) begin errors++; $display("FAIL single_dout got %b want 1001", Digit_out); end
      checks++; if (Fill !== 3'd1) begin errors++; $display("FAIL single_fill got %0d want 1", Fill); end
      drain(2);
      checks++; if (Digit_valid !== 1'b0 || Fill !== 3'd0) begin errors++; $display("FAIL single_drained got valid %b fill %0d want 0 0", Digit_valid, Fill); end
   endtask

   task automatic test_back_to_back();
      logic [3:0] d;
      do_reset();
      Digit_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         d = 4'(k);
         for (int b = 0; b < 4; b++) begin
            @(negedge Clk);
            Bit_en = 1'b1; Bit_first = (b == 0); Z = d[b];
         end
      end
      @(negedge Clk);
      Bit_en = 1'b0; Bit_first = 1'b0;
      repeat (4) @(negedge Clk);
      Digit_ready = 1'b0;
      checks++; if (popq.size() !== 10) begin errors++; $display("FAIL b2b_count got %0d want 10", popq.size()); end
      for (int k = 0; k < 10 && k < popq.size(); k++) begin
         checks++; if (popq[k] !== 4'(k)) begin errors++; $display("FAIL b2b_digit%0d got %0d want %0d", k, popq[k], k); end
      end
      checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL b2b_ovf got %b want 0", Overflow); end
      checks++; if (fe_count !== 0) begin errors++; $display("FAIL b2b_ferr got %0d pulses want 0", fe_count); end
   endtask

   task automatic test_overflow();
      logic [3:0] exp_d [4];
      exp_d[0] = 4'd3; exp_d[1] = 4'd1; exp_d[2] = 4'd4; exp_d[3] = 4'd1;
      do_reset();
      send_digit(4'd3); send_digit(4'd1); send_digit(4'd4); send_digit(4'd1);
      checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b want 0", Overflow); end
      send_digit(4'd5);
      checks++; if (Fill !== 3'd4) begin errors++; $display("FAIL ovf_fill got %0d want 4", Fill); end
      checks++; if (Overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", Overflow); end
      popq.delete();
      drain(8);
      checks++; if (popq.size() !== 4) begin errors++; $display("FAIL ovf_drain_count got %0d want 4", popq.size()); end
      for (int k = 0; k < 4 && k < popq.size(); k++) begin
         checks++; if (popq[k] !== exp_d[k]) begin errors++; $display("FAIL ovf_drain%0d got %0d want %0d", k, popq[k], exp_d[k]); end
      end
      checks++; if (Overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", Overflow); end
   endtask

   task automatic test_full_push_pop();
      do_reset();
      send_digit(4'd2); send_digit(4'd3); send_digit(4'd4); send_digit(4'd5);
      popq.delete();
      send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
      @(negedge Clk);
      Bit_en = 1'b1; Bit_first = 1'b0; Z = 1'b0; Digit_ready = 1'b1;
      @(negedge Clk);
      Bit_en = 1'b0; Digit_ready = 1'b0;
      checks++; if (Fill !== 3'd4) begin errors++; $display("FAIL fullpp_fill got %0d want 4", Fill); end
      checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL fullpp_ovf got %b want 0", Overflow); end
      checks++; if (Digit_out !== 4'd3) begin errors++; $display("FAIL fullpp_head got %0d want 3", Digit_out); end
      drain(6);
      checks++; if (popq.size() !== 5 || popq[0] !== 4'd2 || popq[4] !== 4'd6) begin
         errors++; $display("FAIL fullpp_order got size %0d want 5 ending in 6", popq.size());
      end
   endtask

   task automatic test_framing();
      do_reset();
      send_bit(1'b1, 1'b1);
      send_bit(1'b1, 1'b0);
      checks++; if (Frame_err !== 1'b0) begin errors++; $display("FAIL frame_early got %b want 0", Frame_err); end
      send_bit(1'b0, 1'b1);
      checks++; if (Frame_err !== 1'b1) begin errors++; $display("FAIL frame_pulse got %b want 1", Frame_err); end
      send_bit(1'b1, 1'b0);
      checks++; if (Frame_err !== 1'b0) begin errors++; $display("FAIL frame_clear got %b want 0", Frame_err); end
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      checks++; if (fe_count !== 1) begin errors++; $display("FAIL frame_count got %0d want 1", fe_count); end
      checks++; if (Fill !== 3'd1 || Digit_out !== 4'd6) begin errors++; $display("FAIL frame_digit got fill %0d dout %0d want 1 6", Fill, Digit_out); end
      send_bit(1'b1, 1'b0);
      checks++; if (Frame_err !== 1'b1 || Fill !== 3'd1) begin errors++; $display("FAIL frame_idle_stray got ferr %b fill %0d want 1 1", Frame_err, Fill); end
   endtask

   task automatic test_range();
      do_reset();
      send_bit(1'b0, 1'b1); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
`ifdef BCD_RANGE_CHECK_EN
      checks++; if (Fill !== 3'd0) begin errors++; $display("FAIL range_fill got %0d want 0", Fill); end
      checks++; if (Frame_err !== 1'b1) begin errors++; $display("FAIL range_ferr got %b want 1", Frame_err); end
`else
      checks++; if (Fill !== 3'd1 || Digit_out !== 4'hC) begin errors++; $display("FAIL range_pass got fill %0d dout %h want 1 c", Fill, Digit_out); end
      checks++; if (Frame_err !== 1'b0) begin errors++; $display("FAIL range_ferr got %b want 0", Frame_err); end
`endif
   endtask

   task automatic test_reset_mid();
      do_reset();
      send_digit(4'd8); send_digit(4'd2);
      send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b0);
      checks++; if (Fill !== 3'd2) begin errors++; $display("FAIL rmid_pre_fill got %0d want 2", Fill); end
      @(negedge Clk);
      Rst = 1'b1; Bit_en = 1'b1; Z = 1'b1; Digit_ready = 1'b1;
      @(negedge Clk);
      Rst = 1'b0; Bit_en = 1'b0; Digit_ready = 1'b0;
      checks++; if (Fill !== 3'd0 || Digit_valid !== 1'b0 || Digit_out !== 4'd0) begin
         errors++; $display("FAIL rmid_flush got fill %0d valid %b dout %0d want 0 0 0", Fill, Digit_valid, Digit_out);
      end
      checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL rmid_state got %0d want IDLE", dut.state_q); end
      fe_count = 0;
      send_digit(4'd7);
      checks++; if (Fill !== 3'd1 || Digit_out !== 4'd7 || fe_count !== 0) begin
         errors++; $display("FAIL rmid_next got fill %0d dout %0d ferr %0d want 1 7 0", Fill, Digit_out, fe_count);
      end
   endtask

   initial begin
      test_reset();
      test_single_digit();
      test_back_to_back();
      test_overflow();
      test_full_push_pop();
      test_framing();
      test_range();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
